// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter (scan loader + core).
package sram_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int IMEM_DEPTH = 1024;
  localparam int DMEM_DEPTH = 2048;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    DRAIN    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
    logic is_read;
  } resp_entry_t;

  // imem holds only IMEM_DEPTH words, so its upper address half is out of range
  function automatic logic addr_illegal(input logic id_sel, input logic addr_msb);
    return (id_sel == 1'b0) && (addr_msb == 1'b1);
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin grant with an eligibility mask; pointer names the preferred port.
module sram_rr_arb
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  logic       ptr_r;
  logic [1:0] cand_s;

  // grant: pointer only matters when both eligible ports request
  always_comb begin
    cand_s = req & elig;
    if (cand_s == 2'b11) begin
      gnt = ptr_r ? 2'b10 : 2'b01;
    end else begin
      gnt = cand_s;
    end
  end

  // pointer moves away from the preferred port once it has been served
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (gnt[ptr_r]) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and command sequencer for the imem/dmem spram pair, with
// fixed-latency responses and an exclusive scan lock for port 0.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             p_req,
  input  logic [1:0]             p_we,
  input  logic [1:0]             p_id_sel,
  input  logic [1:0][1:0]        p_seg_id,
  input  logic [1:0][ADDR_W-1:0] p_addr,
  input  logic [1:0][WIDTH-1:0]  p_wdata,
  output logic [1:0]             p_gnt,
  output logic [1:0]             p_rvalid,
  output logic [1:0]             p_err,
  output logic [1:0][WIDTH-1:0]  p_rdata,
  input  logic                   scan_lock_req,
  output logic                   scan_lock_ack,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic                   sram_ren,
  output logic                   sram_id_sel,
  output logic [1:0]             sram_seg_id,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [WIDTH-1:0]       sram_wdata,
  input  logic [WIDTH-1:0]       sram_rdata
);

  lock_state_e state_r;
  resp_entry_t resp0_r;
  resp_entry_t resp1_r;
  logic [1:0]  elig_s;
  logic [1:0]  gnt_s;
  logic        sel_s;
  logic        fire_s;
  logic        illegal_s;
  logic        p1_busy_s;

  sram_rr_arb u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (p_req),
    .elig  (elig_s),
    .gnt   (gnt_s)
  );

  assign p_gnt = gnt_s;

  // eligibility: nothing during reset, port 1 fenced off outside UNLOCKED
  always_comb begin
    elig_s = 2'b00;
    if (!rst_n) begin
      elig_s = 2'b00;
    end else if (state_r == UNLOCKED) begin
      elig_s = 2'b11;
    end else begin
      elig_s = 2'b01;
    end
  end

  // accepted-command decode and port-1 occupancy of the two pipeline stages
  always_comb begin
    sel_s     = gnt_s[1];
    fire_s    = |gnt_s;
    illegal_s = addr_illegal(p_id_sel[sel_s], p_addr[sel_s][ADDR_W-1]);
    p1_busy_s = (resp0_r.valid && resp0_r.port) || (resp1_r.valid && resp1_r.port);
  end

  // lock FSM; ack is registered alongside the LOCKED state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= UNLOCKED;
      scan_lock_ack <= 1'b0;
    end else begin
      case (state_r)
        UNLOCKED: begin
          scan_lock_ack <= 1'b0;
          if (scan_lock_req) state_r <= DRAIN;
          else               state_r <= UNLOCKED;
        end
        DRAIN: begin
          if (!scan_lock_req) begin
            state_r       <= UNLOCKED;
            scan_lock_ack <= 1'b0;
          end else if (!p1_busy_s) begin
            state_r       <= LOCKED;
            scan_lock_ack <= 1'b1;
          end else begin
            state_r       <= DRAIN;
            scan_lock_ack <= 1'b0;
          end
        end
        LOCKED: begin
          if (!scan_lock_req) begin
            state_r       <= UNLOCKED;
            scan_lock_ack <= 1'b0;
          end else begin
            state_r       <= LOCKED;
            scan_lock_ack <= 1'b1;
          end
        end
        default: begin
          state_r       <= UNLOCKED;
          scan_lock_ack <= 1'b0;
        end
      endcase
    end
  end

  // command stage: illegal accesses are granted but never reach the macro
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_cen    <= 1'b0;
      sram_wen    <= 1'b0;
      sram_ren    <= 1'b0;
      sram_id_sel <= 1'b0;
      sram_seg_id <= 2'b00;
      sram_addr   <= {ADDR_W{1'b0}};
      sram_wdata  <= {WIDTH{1'b0}};
    end else if (fire_s && !illegal_s) begin
      sram_cen    <= 1'b1;
      sram_wen    <= p_we[sel_s];
      sram_ren    <= ~p_we[sel_s];
      sram_id_sel <= p_id_sel[sel_s];
      sram_seg_id <= p_seg_id[sel_s];
      sram_addr   <= p_addr[sel_s];
      sram_wdata  <= p_wdata[sel_s];
    end else begin
      sram_cen    <= 1'b0;
      sram_wen    <= 1'b0;
      sram_ren    <= 1'b0;
      sram_id_sel <= 1'b0;
      sram_seg_id <= 2'b00;
      sram_addr   <= {ADDR_W{1'b0}};
      sram_wdata  <= {WIDTH{1'b0}};
    end
  end

  // response shift and one-cycle pulse on the originating port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp0_r  <= '0;
      resp1_r  <= '0;
      p_rvalid <= 2'b00;
      p_err    <= 2'b00;
      p_rdata  <= '0;
    end else begin
      if (fire_s) begin
        resp0_r <= '{valid: 1'b1, port: sel_s, err: illegal_s, is_read: ~p_we[sel_s]};
      end else begin
        resp0_r <= '0;
      end
      resp1_r  <= resp0_r;
      p_rvalid <= 2'b00;
      p_err    <= 2'b00;
      p_rdata  <= '0;
      if (resp1_r.valid) begin
        p_rvalid[resp1_r.port] <= 1'b1;
        p_err[resp1_r.port]    <= resp1_r.err;
        if (resp1_r.is_read && !resp1_r.err) begin
          p_rdata[resp1_r.port] <= sram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a behavioural SRAM drives sram_rdata and a
// transaction-level reference predicts grants, commands, responses and the lock.
module tb_sram_arbiter;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 11;
  localparam int MEM_N  = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [1:0]             p_req, p_we, p_id_sel;
  logic [1:0][1:0]        p_seg_id;
  logic [1:0][ADDR_W-1:0] p_addr;
  logic [1:0][WIDTH-1:0]  p_wdata;
  logic [1:0]             p_gnt, p_rvalid, p_err;
  logic [1:0][WIDTH-1:0]  p_rdata;
  logic                   scan_lock_req, scan_lock_ack;
  logic                   sram_cen, sram_wen, sram_ren, sram_id_sel;
  logic [1:0]             sram_seg_id;
  logic [ADDR_W-1:0]      sram_addr;
  logic [WIDTH-1:0]       sram_wdata, sram_rdata;

  sram_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_id_sel(p_id_sel), .p_seg_id(p_seg_id),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err), .p_rdata(p_rdata),
    .scan_lock_req(scan_lock_req), .scan_lock_ack(scan_lock_ack),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_id_sel(sram_id_sel), .sram_seg_id(sram_seg_id),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic int key(input logic id, input logic [1:0] seg, input logic [ADDR_W-1:0] a);
    return int'({id, seg, a});
  endfunction

  function automatic logic [WIDTH-1:0] init_val(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // behavioural macro: read data one cycle after the command, junk otherwise
  logic             mem_clr;
  logic [WIDTH-1:0] sram_mem [0:MEM_N-1];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_N; i++) sram_mem[i] <= init_val(i);
      sram_rdata <= '0;
    end else begin
      if (sram_cen && sram_wen) sram_mem[key(sram_id_sel, sram_seg_id, sram_addr)] <= sram_wdata;
      if (sram_cen && sram_ren) sram_rdata <= sram_mem[key(sram_id_sel, sram_seg_id, sram_addr)];
      else                      sram_rdata <= $urandom;
    end
  end

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  logic chk_en;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model state
  typedef struct {
    int               due;
    int               port;
    logic             err;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t             rq[$];
  logic [WIDTH-1:0] ref_mem [0:MEM_N-1];
  int               m_state;      // 0 unlocked, 1 drain, 2 locked
  logic             m_ptr;
  logic             m_p1_t1, m_p1_t2;  // port-1 grant one / two cycles ago
  logic [1:0]       g_last;
  logic             e_cen, e_wen, e_ren, e_id;
  logic [1:0]       e_seg;
  logic [ADDR_W-1:0] e_addr;
  logic [WIDTH-1:0] e_wdata;

  task automatic model_cycle();
    logic [1:0]            eff, eg, e_rv, e_er;
    logic [1:0][WIDTH-1:0] e_rd;
    rsp_t                  r;
    int                    p, k;
    logic                  busy;
    eg = 2'b00;
    if (rst_n) begin
      eff = p_req & ((m_state == 0) ? 2'b11 : 2'b01);
      if (eff == 2'b11) eg = m_ptr ? 2'b10 : 2'b01;
      else              eg = eff;
    end
    if (chk_en) begin
      check_eq("gnt", p_gnt, eg);
      check_eq("lock_ack", scan_lock_ack, (m_state == 2));
      check_eq("sram_cmd", {sram_cen, sram_wen, sram_ren, sram_id_sel, sram_seg_id},
               {e_cen, e_wen, e_ren, e_id, e_seg});
      check_eq("sram_addr", sram_addr, e_addr);
      check_eq("sram_wdata", sram_wdata, e_wdata);
      e_rv = 2'b00; e_er = 2'b00; e_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        e_rv[r.port] = 1'b1;
        e_er[r.port] = r.err;
        e_rd[r.port] = r.data;
      end
      check_eq("rvalid", p_rvalid, e_rv);
      check_eq("err", p_err, e_er);
      check_eq("rdata0", p_rdata[0], e_rd[0]);
      check_eq("rdata1", p_rdata[1], e_rd[1]);
    end
    {e_cen, e_wen, e_ren, e_id, e_seg} = '0;
    e_addr = '0; e_wdata = '0;
    if (!rst_n) begin
      m_state = 0; m_ptr = 1'b0; m_p1_t1 = 1'b0; m_p1_t2 = 1'b0;
      rq.delete();
    end else begin
      busy = m_p1_t1 | m_p1_t2;
      if (eg != 2'b00) begin
        p = eg[1] ? 1 : 0;
        r.due  = cyc + 3;
        r.port = p;
        r.err  = (p_id_sel[p] == 1'b0) && (p_addr[p] >= 11'd1024);
        r.data = '0;
        k = key(p_id_sel[p], p_seg_id[p], p_addr[p]);
        if (!r.err) begin
          e_cen = 1'b1; e_wen = p_we[p]; e_ren = ~p_we[p];
          e_id = p_id_sel[p]; e_seg = p_seg_id[p]; e_addr = p_addr[p]; e_wdata = p_wdata[p];
          if (p_we[p]) ref_mem[k] = p_wdata[p];
          else         r.data = ref_mem[k];
        end
        rq.push_back(r);
        if (eg[m_ptr]) m_ptr = ~m_ptr;
      end
      case (m_state)
        0:       if (scan_lock_req) m_state = 1;
        1:       if (!scan_lock_req) m_state = 0; else if (!busy) m_state = 2;
        2:       if (!scan_lock_req) m_state = 0;
        default: m_state = 0;
      endcase
      m_p1_t2 = m_p1_t1;
      m_p1_t1 = eg[1];
    end
    g_last = eg;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) if (g_last[p]) p_req[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int p, input logic we, input logic id, input logic [1:0] seg,
                         input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_id_sel[p] = id;
    p_seg_id[p] = seg; p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic gen_req(input int p, input logic force_read);
    logic [ADDR_W-1:0] a;
    logic              we;
    a = ADDR_W'($urandom_range(0, 7));
    a[ADDR_W-1] = 1'($urandom_range(0, 1));
    we = force_read ? 1'b0 : 1'($urandom_range(0, 1));
    set_req(p, we, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a, $urandom);
  endtask

  task automatic wait_gnt(input int p);
    for (int i = 0; i < 20; i++) begin
      if (!p_req[p]) break;
      step();
    end
    check_eq("gnt_wait", p_req[p], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; p_req = '0; p_we = '0; p_id_sel = '0; p_seg_id = '0;
    p_addr = '0; p_wdata = '0; scan_lock_req = 1'b0;
    mem_clr = 1'b1; chk_en = 1'b0;
    m_state = 0; m_ptr = 1'b0; m_p1_t1 = 1'b0; m_p1_t2 = 1'b0; g_last = '0;
    {e_cen, e_wen, e_ren, e_id, e_seg} = '0; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_val(i);
    @(posedge clk); #1;
    step();
    mem_clr = 1'b0; chk_en = 1'b1; rst_n = 1'b1;

    // core write then read-back of dmem 0x005
    set_req(1, 1'b1, 1'b1, 2'd0, 11'h005, 32'hDEAD_BEEF);
    wait_gnt(1);
    idle(4);
    set_req(1, 1'b0, 1'b1, 2'd0, 11'h005, 32'h0);
    wait_gnt(1);
    idle(4);

    // fresh reset, then both ports request every cycle
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 2; p++) if (!p_req[p]) gen_req(p, 1'b0);
      step();
    end
    p_req = '0;
    idle(4);

    // out-of-range imem read from the scan port
    set_req(0, 1'b0, 1'b0, 2'd0, 11'h400, 32'h0);
    wait_gnt(0);
    idle(4);

    // scan lock while the core streams reads
    for (int i = 0; i < 20; i++) begin
      if (i == 4)  scan_lock_req = 1'b1;
      if (i == 15) scan_lock_req = 1'b0;
      if (!p_req[1]) gen_req(1, 1'b1);
      if (i >= 4 && !p_req[0] && $urandom_range(0, 1) == 1) gen_req(0, 1'b0);
      step();
    end
    p_req = '0;
    idle(5);

    // reset with two commands in flight
    gen_req(0, 1'b1); gen_req(1, 1'b1);
    step();
    for (int p = 0; p < 2; p++) if (!p_req[p]) gen_req(p, 1'b1);
    step();
    rst_n = 1'b0; p_req = '0;
    step();
    rst_n = 1'b1;
    idle(5);

    // random traffic with lock toggling
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 99) < 60) gen_req(p, 1'b0);
      if ($urandom_range(0, 99) < 4) scan_lock_req = ~scan_lock_req;
      step();
    end
    p_req = '0; scan_lock_req = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
